// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - MIPS-style coprocessor 0: SR, Cause, EPC, exception/interrupt request
// Optional build macro: CP0_PRID_EN (register 15 reads a constant PRId when defined)
module cp0_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic        req,
  output logic [31:0] epc_out
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // SR fields
  logic [5:0]  im_q;
  logic        exl_q;
  logic        ie_q;
  // Cause fields
  logic        bd_q;
  logic [5:0]  ip_q;
  logic [4:0]  exc_code_q;
  // EPC
  logic [31:0] epc_q;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  assign sr_word    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_word = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};

  // Request generation from current state and live interrupt lines
  always_comb begin
    int_req = (|(hw_int & im_q)) & ie_q & ~exl_q;
    exc_req = (exc_code_in != 5'd0) & ~exl_q;
    req     = int_req | exc_req;
  end

  // Register read mux; reads always see the pre-write value
  always_comb begin
    rdata = 32'b0;
    case (addr)
      ADDR_SR:    rdata = sr_word;
      ADDR_CAUSE: rdata = cause_word;
      ADDR_EPC:   rdata = epc_q;
`ifdef CP0_PRID_EN
      ADDR_PRID:  rdata = 32'h4D495053;
`else
      ADDR_PRID:  rdata = 32'b0;
`endif
      default:    rdata = 32'b0;
    endcase
  end

  assign epc_out = epc_q;

  // State update: reset, then exception entry, then mtc0 followed by eret clear
  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= 6'b0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'b0;
      exc_code_q <= 5'b0;
      epc_q      <= 32'b0;
    end else begin
      ip_q <= hw_int;
      if (req) begin
        exl_q      <= 1'b1;
        bd_q       <= bd_in;
        epc_q      <= bd_in ? (vpc - 32'd4) : vpc;
        exc_code_q <= int_req ? 5'd0 : exc_code_in;
      end else begin
        if (en && addr == ADDR_SR) begin
          im_q  <= wdata[15:10];
          exl_q <= wdata[1];
          ie_q  <= wdata[0];
        end
        if (en && addr == ADDR_EPC) begin
          epc_q <= wdata;
        end
        // eret wins over a same-cycle SR write to EXL
        if (exl_clr) begin
          exl_q <= 1'b0;
        end
      end
    end
  end

endmodule
